// File: rtl/mem8x8_ctrl_if.sv
// Request handshake plus memory pin bundle for mem8x8_ctrl.
// master: requester and memory side; slave: the controller.
interface mem8x8_ctrl_if;
    logic       req;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       err;
    logic [2:0] mem_address;
    logic [7:0] mem_data_in;
    logic       mem_select;
    logic       mem_rw;
    logic [7:0] mem_data_out;

    modport master (
        output req, we, addr, wdata, mem_data_out,
        input  busy, done, rdata, err,
        input  mem_address, mem_data_in, mem_select, mem_rw
    );

    modport slave (
        input  req, we, addr, wdata, mem_data_out,
        output busy, done, rdata, err,
        output mem_address, mem_data_in, mem_select, mem_rw
    );
endinterface

// File: rtl/mem8x8_ctrl.sv
// Sequencing front end for the 8x8 register memory: holds address/data/rw
// stable for programmable cycle counts and reads back every write.
module mem8x8_ctrl #(
    parameter int unsigned WR_CYCLES = 3,
    parameter int unsigned RD_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    mem8x8_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        RECOVER,
        READ,
        DONE
    } state_t;

    // Counter is loaded with cycles-1 so a state is left when it reads 0.
    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [2:0] addr_q;
    logic [7:0] wdata_q;
    logic       we_q;
    logic       accept;
    logic       read_last;

    assign accept    = (state == IDLE) && bus.req;
    assign read_last = (state == READ) && (cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.req) state_nx = SETUP;
            SETUP:   state_nx = we_q ? WRITE : READ;
            WRITE:   if (cnt == '0) state_nx = RECOVER;
            RECOVER: state_nx = READ;
            READ:    if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request capture; memory pins are driven only from these registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            we_q    <= bus.we;
        end
    end

    // Shared down-counter: loaded on entry to WRITE/READ, stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nx == WRITE && state != WRITE) begin
            cnt <= WR_LOAD;
        end else if (state_nx == READ && state != READ) begin
            cnt <= RD_LOAD;
        end else if ((state == WRITE || state == READ) && cnt != '0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Result capture on the last READ cycle; err clears on each accepted req.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rdata <= '0;
            bus.err   <= 1'b0;
        end else if (accept) begin
            bus.err   <= 1'b0;
        end else if (read_last) begin
            bus.rdata <= bus.mem_data_out;
            bus.err   <= we_q && (bus.mem_data_out != wdata_q);
        end
    end

    // Output decode from the current state.
    always_comb begin
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.mem_select  = 1'b0;
        bus.mem_rw      = 1'b0;
        bus.mem_address = addr_q;
        bus.mem_data_in = wdata_q;
        unique case (state)
            SETUP, RECOVER, READ: begin
                bus.busy       = 1'b1;
                bus.mem_select = 1'b1;
            end
            WRITE: begin
                bus.busy       = 1'b1;
                bus.mem_select = 1'b1;
                bus.mem_rw     = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Directed bench for mem8x8_ctrl with a behavioural 8x8 memory and a
// scoreboard of expected completions.
module tb_mem8x8_ctrl;

    localparam int unsigned WR = 3;
    localparam int unsigned RD = 2;

    typedef struct {
        logic [7:0]  rdata;
        logic        err;
        int unsigned lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic force_zero;
    logic [7:0] mem [8];
    logic [7:0] ref_mem [8];
    exp_t sb [$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    mem8x8_ctrl_if bus ();

    mem8x8_ctrl #(
        .WR_CYCLES(WR),
        .RD_CYCLES(RD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural memory8x8: registered write, combinational read.
    always @(posedge clk) begin
        if (bus.mem_select && bus.mem_rw) mem[bus.mem_address] <= bus.mem_data_in;
    end
    assign bus.mem_data_out = force_zero ? 8'h00 : mem[bus.mem_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access; poke != 0 pulses req (addr 7) on that cycle of the access.
    task automatic do_access(input logic w, input logic [2:0] a, input logic [7:0] d,
                             input logic fz, input int unsigned poke);
        exp_t e;
        exp_t got_e;
        int unsigned cyc;
        int unsigned rw_n;
        logic stable_ok;
        logic busy_ok;
        if (w) begin
            ref_mem[a] = d;
            e.rdata = fz ? 8'h00 : d;
            e.err   = fz;
            e.lat   = 3 + WR + RD;
        end else begin
            e.rdata = ref_mem[a];
            e.err   = 1'b0;
            e.lat   = 2 + RD;
        end
        sb.push_back(e);
        force_zero = fz;
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        step();
        bus.req = 1'b0; bus.addr = ~a; bus.wdata = ~d;
        cyc = 1; rw_n = 0; stable_ok = 1'b1; busy_ok = 1'b1;
        check("err_clear_on_accept", 32'(bus.err), 32'd0);
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy !== 1'b1 || bus.mem_select !== 1'b1) busy_ok = 1'b0;
            if (bus.mem_address !== a) stable_ok = 1'b0;
            if (bus.mem_rw === 1'b1) begin
                rw_n++;
                if (bus.mem_data_in !== d) stable_ok = 1'b0;
            end
            if (poke != 0 && cyc == poke) begin
                bus.req = 1'b1; bus.addr = 3'd7;
            end else begin
                bus.req = 1'b0;
            end
            step();
            cyc++;
        end
        bus.req = 1'b0;
        check("done_seen", 32'(bus.done), 32'd1);
        got_e = sb.pop_front();
        if (bus.done === 1'b1) begin
            check("latency", cyc, got_e.lat);
            check("rdata", 32'(bus.rdata), 32'(got_e.rdata));
            check("err", 32'(bus.err), 32'(got_e.err));
            check("busy_low_in_done", 32'(bus.busy), 32'd0);
            check("select_low_in_done", 32'(bus.mem_select), 32'd0);
            check("busy_window", 32'(busy_ok), 32'd1);
            check("pins_stable", 32'(stable_ok), 32'd1);
            check("rw_cycles", rw_n, w ? WR : 0);
        end
        step();
        force_zero = 1'b0;
    endtask

    initial begin
        logic extra_done;
        force_zero = 1'b0;
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

        // Reset
        step();
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_mem_address", 32'(bus.mem_address), 32'd0);
        check("rst_mem_data_in", 32'(bus.mem_data_in), 32'd0);
        check("rst_mem_select", 32'(bus.mem_select), 32'd0);
        check("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
        rst = 1'b0;
        step();

        // Basic write/read, overwrite, second address
        do_access(1'b1, 3'd0, 8'hAA, 1'b0, 0);
        do_access(1'b0, 3'd0, 8'h00, 1'b0, 0);
        do_access(1'b1, 3'd0, 8'h55, 1'b0, 0);
        do_access(1'b1, 3'd1, 8'h15, 1'b0, 0);
        do_access(1'b0, 3'd0, 8'h00, 1'b0, 0);
        do_access(1'b0, 3'd1, 8'h00, 1'b0, 0);

        // Read-back mismatch, then err clears on the next accepted req
        do_access(1'b1, 3'd3, 8'hFF, 1'b1, 0);
        do_access(1'b0, 3'd3, 8'h00, 1'b0, 0);

        // Request during busy is ignored
        do_access(1'b0, 3'd1, 8'h00, 1'b0, 2);
        extra_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra_done = 1'b1;
            step();
        end
        check("no_second_access", 32'(extra_done), 32'd0);
        check("rdata_held", 32'(bus.rdata), 32'h15);

        // Reset in the second WRITE cycle
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 3'd2; bus.wdata = 8'h3C;
        step();
        bus.req = 1'b0;
        step();
        step();
        check("mid_write_rw_high", 32'(bus.mem_rw), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_mem_rw", 32'(bus.mem_rw), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_mem_select", 32'(bus.mem_select), 32'd0);
        extra_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done !== 1'b0) extra_done = 1'b1;
            step();
        end
        check("abort_no_done", 32'(extra_done), 32'd0);
        // The behavioural memory commits on the first WRITE edge already.
        ref_mem[2] = 8'h3C;
        do_access(1'b0, 3'd2, 8'h00, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
